// File: rtl/uart_msg_pkg.sv
// Shared definitions for the message UART transmitter: sequencer state encoding and 8N1 frame constants.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } msg_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic        LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: start bit begins the cycle after stb && !busy; every bit lasts CLKS_PER_BAUD clocks.
// The caller holds stb until accepted; busy covers the whole frame up to the end of the stop bit.
module uart_tx_core
  import uart_msg_pkg::*;
#(
  parameter logic [23:0] CLKS_PER_BAUD = 24'd868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stb,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  logic [23:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;  // bits still to go after the one on the line: data, then stop

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx       <= LINE_IDLE;
      busy     <= 1'b0;
    end else if (!busy) begin
      if (stb) begin
        busy     <= 1'b1;
        tx       <= 1'b0;
        shreg    <= {1'b1, data};
        bit_cnt  <= '0;
        baud_cnt <= CLKS_PER_BAUD - 24'd1;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - 24'd1;
    end else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
      busy <= 1'b0;
    end else begin
      tx       <= shreg[0];
      shreg    <= {1'b1, shreg[8:1]};
      bit_cnt  <= bit_cnt + 4'd1;
      baud_cnt <= CLKS_PER_BAUD - 24'd1;
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Sends an MSG_LEN-character message held in a writable RAM over an 8N1 UART; i_start is ignored while busy.
// Define UART_MSG_AUTO_REPEAT_EN to also launch the message every REPEAT_CLKS clocks (one request may pend).
module uart_msg_tx
  import uart_msg_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned MSG_LEN       = 16,
  parameter int unsigned REPEAT_CLKS   = CLOCK_RATE_HZ,
  localparam logic [23:0] CLKS_PER_BAUD = 24'(CLOCK_RATE_HZ / BAUD_RATE),
  localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_wr,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_index,
  output logic          o_uart_tx
);

  localparam int unsigned   LAST     = MSG_LEN - 1;
  localparam logic [AW:0]   LEN_W    = MSG_LEN[AW:0];
  localparam logic [AW-1:0] LAST_IDX = LAST[AW-1:0];

  logic [7:0]    msg_ram [2**AW] = '{default: 8'h20};
  logic [7:0]    char_q;
  msg_state_t    state, state_nx;
  logic [AW-1:0] idx_nx;
  logic          core_stb, core_busy, start_req;

  // The RAM keeps its contents across reset; out-of-range writes are dropped rather than aliased.
  always_ff @(posedge i_clk) begin
    if (i_wr && ({1'b0, i_waddr} < LEN_W)) msg_ram[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (state == ST_FETCH) char_q <= msg_ram[o_index];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      o_index <= '0;
    end else begin
      state   <= state_nx;
      o_index <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = o_index;
    o_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_nx = ST_FETCH;
          idx_nx   = '0;
        end
      end
      ST_FETCH: state_nx = ST_SEND;
      ST_SEND: begin
        if (!core_busy) begin
          if (o_index == LAST_IDX) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_FETCH;
            idx_nx   = o_index + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!core_busy) begin
          o_done   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign o_busy   = (state != ST_IDLE) && !o_done;
  assign core_stb = (state == ST_SEND);

`ifdef UART_MSG_AUTO_REPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_fire, rep_pend;

  assign rep_fire = (rep_cnt == '0);

  // An expiry that lands while a message is in flight is remembered once; extra expiries are dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rep_cnt  <= 32'(REPEAT_CLKS - 1);
      rep_pend <= 1'b0;
    end else begin
      rep_cnt <= rep_fire ? 32'(REPEAT_CLKS - 1) : rep_cnt - 32'd1;
      if (state == ST_IDLE) rep_pend <= 1'b0;
      else if (rep_fire)    rep_pend <= 1'b1;
    end
  end

  assign start_req = i_start || rep_fire || rep_pend;
`else
  logic unused_repeat;  // the repeat period only matters when auto-repeat is built in

  assign unused_repeat = (REPEAT_CLKS == 0);
  assign start_req     = i_start;
`endif

  uart_tx_core #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_core (
    .clk  (i_clk),
    .reset(i_reset),
    .stb  (core_stb),
    .data (char_q),
    .tx   (o_uart_tx),
    .busy (core_busy)
  );

endmodule
